pipelined_carry_adder: RTL

- Parametrised, pipelined successor to the team's 4-bit ripple-carry adder: WIDTH-bit a + b + cin, split into STAGES equal chunks.
- Each chunk is a ripple of full adders, and the carry between chunks is registered.
- Valid/ready streaming interface with backpressure, one result per cycle at full throughput.
- Sits in datapaths needing wide adds at clock rates a single WIDTH-bit ripple cannot meet.

---
 rtl/pipelined_carry_adder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit a + b + cin, split into STAGES equal
// ripple-carry chunks with a registered carry between chunks.
// Valid/ready streaming with backpressure, one result per cycle.
// Optional macro PIPELINED_CARRY_ADDER_OVF_EN adds a registered signed
// overflow output 'ovf'.
//
// Handshake: a transfer in happens on an edge where in_valid & in_ready,
// a transfer out on an edge where out_valid & out_ready. The whole pipe
// advances when (!out_valid | out_ready); in_ready equals that advance term
// and never depends on in_valid. Bubbles shift like data.
module pipelined_carry_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_CARRY_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_carry_adder: WIDTH must be >= 1 and divisible by STAGES");
  end

  // Per-stage registered state, exported so the next stage can read it.
  logic [WIDTH-1:0] opa_s  [STAGES];
  logic [WIDTH-1:0] opb_s  [STAGES];
  logic [WIDTH-1:0] psum_s [STAGES];
  logic [STAGES-1:0] cy_s;
  logic [STAGES-1:0] vld_s;
  logic              advance;

  // Pipe moves whenever the output slot is empty or being consumed.
  always_comb begin
    advance = !vld_s[STAGES-1] | out_ready;
  end

  assign in_ready  = advance;
  assign out_valid = vld_s[STAGES-1];
  assign sum       = psum_s[STAGES-1];
  assign cout      = cy_s[STAGES-1];

  // The final stage's operand copies have no consumer.
  logic unused_last_operands;
  assign unused_last_operands = ^{opa_s[STAGES-1], opb_s[STAGES-1]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam bit LAST = (k == STAGES - 1);

    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in, v_in;
    logic [CHUNK:0]   chain;
    logic [WIDTH-1:0] psum_new;
    logic             load;

    logic             vld_q, vld_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] psum_q, psum_d;

    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = b;
      assign s_in = '0;
      assign c_in = cin;
      assign v_in = in_valid & in_ready;
    end else begin : g_body
      assign a_in = opa_s[k-1];
      assign b_in = opb_s[k-1];
      assign s_in = psum_s[k-1];
      assign c_in = cy_s[k-1];
      assign v_in = vld_s[k-1];
    end

    // Full-adder ripple across chunk k, merged into the lower partial sum.
    always_comb begin
      chain    = '0;
      chain[0] = c_in;
      psum_new = s_in;
      for (int i = 0; i < CHUNK; i++) begin
        psum_new[k*CHUNK+i] = a_in[k*CHUNK+i] ^ b_in[k*CHUNK+i] ^ chain[i];
        chain[i+1] = (a_in[k*CHUNK+i] & b_in[k*CHUNK+i]) |
                     (chain[i] & (a_in[k*CHUNK+i] ^ b_in[k*CHUNK+i]));
      end
    end

    // Inner stages load on every advance; the output stage only on valid
    // slots so sum/cout stay put across bubbles.
    always_comb begin
      load   = LAST ? (advance & v_in) : advance;
      vld_d  = advance ? v_in : vld_q;
      cy_d   = load ? chain[CHUNK] : cy_q;
      opa_d  = load ? a_in : opa_q;
      opb_d  = load ? b_in : opb_q;
      psum_d = load ? psum_new : psum_q;
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        cy_q   <= 1'b0;
        opa_q  <= '0;
        opb_q  <= '0;
        psum_q <= '0;
      end else begin
        vld_q  <= vld_d;
        cy_q   <= cy_d;
        opa_q  <= opa_d;
        opb_q  <= opb_d;
        psum_q <= psum_d;
      end
    end

    assign opa_s[k]  = opa_q;
    assign opb_s[k]  = opb_q;
    assign psum_s[k] = psum_q;
    assign cy_s[k]   = cy_q;
    assign vld_s[k]  = vld_q;

`ifdef PIPELINED_CARRY_ADDER_OVF_EN
    if (LAST) begin : g_ovf
      logic ovf_q, ovf_d;

      // Signed overflow: carry into MSB differs from carry out of MSB.
      always_comb begin
        ovf_d = load ? (chain[CHUNK] ^ chain[CHUNK-1]) : ovf_q;
      end

      // Overflow flag, registered in lockstep with sum.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end

      assign ovf = ovf_q;
    end
`endif
  end

endmodule
